// File: rtl/reaction_timer_sequencer.sv
// Reaction timer control FSM: random pre-stimulus delay, stimulus LED, millisecond
// reaction count, best-time tracking, and early-press / timeout flags.
module reaction_timer_sequencer #(
   parameter int unsigned TICKS_PER_MS = 50000,
   parameter int unsigned MIN_DELAY_MS = 1000,
   parameter logic [15:0] RAND_MASK    = 16'h07FF,
   parameter int unsigned MAX_MS       = 999
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start_btn,
   input  logic        react_btn,
   output logic        led_stim,
   output logic [23:0] reaction_time,
   output logic [23:0] best_time,
   output logic        time_valid,
   output logic        early_flag,
   output logic        timeout_flag,
   output logic        busy
);

   localparam int unsigned   TW        = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;
   localparam logic [TW-1:0] TICK_LAST = TW'(TICKS_PER_MS - 1);
   localparam logic [23:0]   MIN_V     = 24'(MIN_DELAY_MS);
   localparam logic [23:0]   MAX_V     = 24'(MAX_MS);
   localparam logic [15:0]   LFSR_SEED = 16'hACE1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT_DELAY,
      S_STIM,
      S_SHOW,
      S_FAULT
   } state_t;

   state_t        r_state, w_state_nxt;
   logic [15:0]   r_lfsr, w_lfsr_nxt;
   logic [TW-1:0] r_tick_cnt, w_tick_cnt_nxt;
   logic [23:0]   r_delay_ms, w_delay_ms_nxt;
   logic [23:0]   r_ms_cnt, w_ms_cnt_nxt;
   logic [23:0]   r_reaction_time, w_reaction_time_nxt;
   logic [23:0]   r_best_time, w_best_time_nxt;
   logic          r_time_valid, w_time_valid_nxt;
   logic          r_timeout_flag, w_timeout_flag_nxt;
   logic          r_led_stim, r_early_flag, r_busy;
   logic          w_led_stim_nxt, w_early_flag_nxt, w_busy_nxt;
   logic          w_tick, w_tick_clr;
   logic [23:0]   w_new_delay;

   assign w_tick      = (r_tick_cnt == TICK_LAST);
   assign w_new_delay = MIN_V + {8'd0, r_lfsr & RAND_MASK};
   // Fibonacci taps 16,14,13,11; a non-zero seed keeps it off the all-zero lock-up state.
   assign w_lfsr_nxt  = {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};

   always_comb begin
      // NOTE: every next-value gets its hold value first, so no path can infer a latch.
      w_state_nxt         = r_state;
      w_delay_ms_nxt      = r_delay_ms;
      w_ms_cnt_nxt        = r_ms_cnt;
      w_reaction_time_nxt = r_reaction_time;
      w_best_time_nxt     = r_best_time;
      w_time_valid_nxt    = r_time_valid;
      w_timeout_flag_nxt  = r_timeout_flag;
      w_tick_clr          = 1'b0;

      case (r_state)
         S_IDLE, S_SHOW, S_FAULT: begin
            if (start_btn) begin
               w_state_nxt        = S_WAIT_DELAY;
               w_delay_ms_nxt     = w_new_delay;
               w_tick_clr         = 1'b1;
               w_time_valid_nxt   = 1'b0;
               w_timeout_flag_nxt = 1'b0;
            end
         end
         S_WAIT_DELAY: begin
            // An early press beats a coincident final delay tick.
            if (react_btn) begin
               w_state_nxt         = S_FAULT;
               w_reaction_time_nxt = 24'd0;
            end else if (w_tick) begin
               w_delay_ms_nxt = r_delay_ms - 24'd1;
               if (r_delay_ms <= 24'd1) begin
                  w_state_nxt  = S_STIM;
                  w_ms_cnt_nxt = 24'd0;
                  w_tick_clr   = 1'b1;
               end
            end
         end
         S_STIM: begin
            if (react_btn) begin
               w_state_nxt         = S_SHOW;
               w_reaction_time_nxt = r_ms_cnt;
               w_time_valid_nxt    = 1'b1;
               if (r_ms_cnt < r_best_time) w_best_time_nxt = r_ms_cnt;
            end else if (w_tick) begin
               w_ms_cnt_nxt = r_ms_cnt + 24'd1;
               if (r_ms_cnt + 24'd1 >= MAX_V) begin
                  w_state_nxt         = S_SHOW;
                  w_reaction_time_nxt = MAX_V;
                  w_timeout_flag_nxt  = 1'b1;
               end
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase

      w_tick_cnt_nxt   = (w_tick_clr || w_tick) ? '0 : r_tick_cnt + 1'b1;
      w_led_stim_nxt   = (w_state_nxt == S_STIM);
      w_early_flag_nxt = (w_state_nxt == S_FAULT);
      w_busy_nxt       = (w_state_nxt == S_WAIT_DELAY) || (w_state_nxt == S_STIM);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state         <= S_IDLE;
         r_lfsr          <= LFSR_SEED;
         r_tick_cnt      <= '0;
         r_delay_ms      <= 24'd0;
         r_ms_cnt        <= 24'd0;
         r_reaction_time <= 24'd0;
         r_best_time     <= MAX_V;
         r_time_valid    <= 1'b0;
         r_timeout_flag  <= 1'b0;
         r_led_stim      <= 1'b0;
         r_early_flag    <= 1'b0;
         r_busy          <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         r_state         <= w_state_nxt;
         r_lfsr          <= w_lfsr_nxt;
         r_tick_cnt      <= w_tick_cnt_nxt;
         r_delay_ms      <= w_delay_ms_nxt;
         r_ms_cnt        <= w_ms_cnt_nxt;
         r_reaction_time <= w_reaction_time_nxt;
         r_best_time     <= w_best_time_nxt;
         r_time_valid    <= w_time_valid_nxt;
         r_timeout_flag  <= w_timeout_flag_nxt;
         r_led_stim      <= w_led_stim_nxt;
         r_early_flag    <= w_early_flag_nxt;
         r_busy          <= w_busy_nxt;
      end
   end

   assign led_stim      = r_led_stim;
   assign reaction_time = r_reaction_time;
   assign best_time     = r_best_time;
   assign time_valid    = r_time_valid;
   assign early_flag    = r_early_flag;
   assign timeout_flag  = r_timeout_flag;
   assign busy          = r_busy;

endmodule

// File: tb/tb_reaction_timer_sequencer.sv
// Scoreboard bench: stimulus pushes expected results, a monitor pops them when a
// result flag rises. A second instance exercises the random delay with a reference LFSR.
module tb_reaction_timer_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        start_a, react_a, start_r, react_r;
   logic        led_a, tv_a, ef_a, to_a, busy_a;
   logic [23:0] rt_a, best_a;
   logic        led_r, tv_r, ef_r, to_r, busy_r;
   logic [23:0] rt_r, best_r;

   always #5 clk = ~clk;

   reaction_timer_sequencer #(
      .TICKS_PER_MS(4), .MIN_DELAY_MS(3), .RAND_MASK(16'h0000), .MAX_MS(999)
   ) dut (
      .clk(clk), .rst(rst), .start_btn(start_a), .react_btn(react_a),
      .led_stim(led_a), .reaction_time(rt_a), .best_time(best_a),
      .time_valid(tv_a), .early_flag(ef_a), .timeout_flag(to_a), .busy(busy_a)
   );

   reaction_timer_sequencer #(
      .TICKS_PER_MS(4), .MIN_DELAY_MS(1000), .RAND_MASK(16'h07FF), .MAX_MS(999)
   ) dut_r (
      .clk(clk), .rst(rst), .start_btn(start_r), .react_btn(react_r),
      .led_stim(led_r), .reaction_time(rt_r), .best_time(best_r),
      .time_valid(tv_r), .early_flag(ef_r), .timeout_flag(to_r), .busy(busy_r)
   );

   // Expected result flags are {time_valid, timeout_flag, early_flag}.
   typedef struct {
      logic [2:0]  flags;
      logic [23:0] rt;
      logic [23:0] best;
   } exp_t;

   exp_t        exp_q[$];
   int          n_checks = 0;
   int          n_fail   = 0;
   int          model_best;
   logic [15:0] m_lfsr;

   // Reference LFSR for the random-delay instance: taps 16,14,13,11, seed ACE1.
   always @(posedge clk or posedge rst) begin
      if (rst) m_lfsr <= 16'hACE1;
      else     m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: actual=%0d required=%0d", name, act, req);
      end
   endtask

   task automatic push(input logic [2:0] f, input int rt);
      exp_t e;
      if (f == 3'b100 && rt < model_best) model_best = rt;
      e.flags = f;
      e.rt    = 24'(rt);
      e.best  = 24'(model_best);
      exp_q.push_back(e);
   endtask

   task automatic pulse_start_a();
      start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
   endtask

   task automatic pulse_react_a();
      react_a = 1'b1;
      @(negedge clk);
      react_a = 1'b0;
   endtask

   task automatic wait_led_a(output int n);
      n = 0;
      while (led_a !== 1'b1 && n < 20000) begin
         @(negedge clk);
         n++;
      end
   endtask

   // One full trial capturing v ms; on_tick places the press on a tick edge so that
   // tick must not be counted; poke_start presses start once mid-STIM.
   task automatic capture_a(input int v, input bit on_tick, input bit poke_start);
      int n;
      int m;
      pulse_start_a();
      check("busy_on_start", busy_a, 1);
      check("valid_cleared", tv_a, 0);
      wait_led_a(n);
      check("stim_delay", n, 12);
      m = on_tick ? 4 * v + 3 : 4 * v + 1;
      for (int i = 0; i < m; i++) begin
         start_a = poke_start && (i == 10);
         @(negedge clk);
      end
      start_a = 1'b0;
      push(3'b100, v);
      pulse_react_a();
      check("led_off_show", led_a, 0);
      check("busy_off_show", busy_a, 0);
   endtask

   // Monitor: a rising result flag means the DUT is presenting a result.
   initial begin
      logic [2:0] prev;
      logic [2:0] cur;
      exp_t       e;
      prev = 3'b000;
      forever begin
         @(negedge clk);
         cur = {tv_a, to_a, ef_a};
         if (rst) begin
            prev = 3'b000;
         end else begin
            if ((cur & ~prev) != 3'b000) begin
               if (exp_q.size() == 0) begin
                  n_checks++;
                  n_fail++;
                  $display("FAIL unexpected_result: flags=%b rt=%0d", cur, rt_a);
               end else begin
                  e = exp_q.pop_front();
                  check("result_flags", 32'(cur), 32'(e.flags));
                  check("result_time", rt_a, e.rt);
                  check("result_best", best_a, e.best);
               end
            end
            prev = cur;
         end
      end
   end

   initial begin
      int n;
      int exp_d;
      int d[3];
      rst = 1'b1; start_a = 1'b0; react_a = 1'b0; start_r = 1'b0; react_r = 1'b0;
      model_best = 999;
      repeat (3) @(negedge clk);
      check("rst_led", led_a, 0);
      check("rst_rt", rt_a, 0);
      check("rst_best", best_a, 999);
      check("rst_flags", {tv_a, to_a, ef_a}, 0);
      check("rst_busy", busy_a, 0);
      rst = 1'b0;
      @(negedge clk);

      pulse_react_a();
      check("idle_react_ignored", {busy_a, ef_a}, 0);

      capture_a(25, 1'b0, 1'b0);
      pulse_react_a();
      check("show_hold_rt", rt_a, 25);
      check("show_hold_valid", tv_a, 1);

      capture_a(40, 1'b0, 1'b1);
      capture_a(12, 1'b1, 1'b0);

      // Early press well inside the delay.
      pulse_start_a();
      repeat (4) @(negedge clk);
      push(3'b001, 0);
      pulse_react_a();
      check("early_busy", busy_a, 0);
      repeat (20) @(negedge clk);
      check("early_led_never", led_a, 0);
      pulse_react_a();
      check("fault_react_ignored", ef_a, 1);

      // Press on the final delay tick must still fault.
      pulse_start_a();
      check("early_cleared", ef_a, 0);
      check("restart_busy", busy_a, 1);
      repeat (11) @(negedge clk);
      push(3'b001, 0);
      pulse_react_a();
      check("final_tick_led", led_a, 0);

      // Timeout after MAX_MS ticks of STIM.
      pulse_start_a();
      wait_led_a(n);
      check("timeout_stim_delay", n, 12);
      push(3'b010, 999);
      n = 0;
      while (to_a !== 1'b1 && n < 5000) begin
         @(negedge clk);
         n++;
      end
      check("timeout_cycles", n, 3996);
      check("timeout_led", led_a, 0);
      pulse_react_a();
      check("timeout_hold_rt", rt_a, 999);
      check("timeout_hold_flag", to_a, 1);

      // Press on the timeout tick is a normal capture of MAX_MS-1.
      capture_a(998, 1'b1, 1'b0);

      // Asynchronous reset mid-STIM, between clock edges.
      pulse_start_a();
      wait_led_a(n);
      repeat (5) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("async_led", led_a, 0);
      check("async_busy", busy_a, 0);
      check("async_best", best_a, 999);
      check("async_flags", {tv_a, to_a, ef_a}, 0);
      model_best = 999;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // Random delays checked against the reference LFSR and the legal range.
      for (int t = 0; t < 3; t++) begin
         exp_d = 1000 + int'(m_lfsr & 16'h07FF);
         start_r = 1'b1;
         @(negedge clk);
         start_r = 1'b0;
         n = 0;
         while (led_r !== 1'b1 && n < 13000) begin
            @(negedge clk);
            n++;
         end
         check("rand_delay", n, exp_d * 4);
         check("rand_range", (n >= 4000) && (n <= 12188), 1);
         d[t] = n;
         react_r = 1'b1;
         @(negedge clk);
         react_r = 1'b0;
      end
      check("rand_varies", (d[0] != d[1]) || (d[1] != d[2]), 1);

      n = 0;
      while (exp_q.size() != 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("pending_results", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
